mips_regfile: RTL and testbench
===============================

Name: mips_regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the 32-bit ALU: read port 1 drives the ALU A operand and read port 2 drives the B operand (before immediate muxing).
- The single write port takes the ALU result, or the memory load data, from the writeback path.
- Register $0 is hard-wired to zero. The file has write-through bypass so a same-cycle write is visible on the read ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREGS, 32, register count; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all register updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs_addr  input  ADDR_W  read port 1 address (instruction rs field).
- rt_addr  input  ADDR_W  read port 2 address (instruction rt field).
- rs_data  output  DATA_W  read port 1 data, feeds ALU A.
- rt_data  output  DATA_W  read port 2 data, feeds ALU B path.
- we  input  1  write enable from the control unit (RegWrite).
- wr_addr  input  ADDR_W  write address (rd or rt, selected upstream by RegDst).
- wr_data  input  DATA_W  write data (ALU result or load data).
- dbg_addr  input  ADDR_W  debug/testbench read address.
- dbg_data  output  DATA_W  debug read data; raw register content, no bypass.

Behaviour:
- Reset: rst_n low clears all NREGS registers to 0 immediately, with no clock required. While rst_n is low, all outputs read 0 and writes are ignored.
- Deassertion: the first write can take effect on the first rising clk edge after rst_n goes high.
- Write: on rising clk, if we=1, rst_n=1 and wr_addr!=0, then reg[wr_addr] <= wr_data. Otherwise there is no state change.
- $0:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including when we=1 and wr_addr=0 in the same cycle.
- Read ports are combinational (zero latency):
  - rs_data = 0 if rs_addr==0.
  - Else rs_data = wr_data if (we && wr_addr==rs_addr), the write-through bypass.
  - Else rs_data = reg[rs_addr].
  - rt_data follows the same rule with rt_addr.
- Bypass is purely combinational. It lets a writeback in cycle N be observed by the ALU operand read in the same cycle N.
- Both read ports may address the same register, and may both match the write address. Both then return the same bypassed value.
- Write and reset coincident: reset wins and the register stays 0.
- Reset mid-operation (rst_n falls between edges): all contents clear at once. A write pending on the next edge is lost if rst_n is still low at that edge.
- dbg_data = reg[dbg_addr] with no bypass; dbg_addr=0 returns 0.
- No X propagation: undriven addresses are not legal stimulus, but all 32 addresses are decoded fully.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W=32 and REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - Named register indices used by the bench: REG_T0=8, REG_SP=29, REG_RA=31.
- One sub-module is natural: regfile_read_port. It contains the address-0 check, bypass compare and storage mux. It is instantiated twice, for rs and rt.
- Storage and the write/reset logic stay in mips_regfile.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, then assert rst_n=0 mid-cycle -> rs_data with rs_addr=5 reads 0 immediately, without waiting for a clk edge.
- Basic write/read: we=1, wr_addr=8, wr_data=0x00000011, one edge; then rs_addr=8 and rt_addr=8 -> both read 0x00000011, and dbg_data at dbg_addr=8 also reads 0x00000011.
- $0 immutability: we=1, wr_addr=0, wr_data=0xFFFFFFFF over an edge -> rs_addr=0 reads 0 before, during and after the edge, and dbg_data at dbg_addr=0 reads 0.
- Write-through bypass: r9 holds 0x5, then in the same cycle drive we=1, wr_addr=9, wr_data=0x7 with rs_addr=9 -> rs_data=0x7 before the edge while dbg_data=0x5; after the edge dbg_data=0x7.
- Dual-port independence: r1=0x00000003, r2=0x00000001, with rs_addr=1, rt_addr=2 -> rs_data=3 and rt_data=1. Feeding the ALU with S=110 (subtract) yields 2.
- Exhaustive sweep: write reg[i]=i*0x01010101 for i=1..31, then read all 31 pairs (rs=i, rt=31-i) -> every read matches, and r0 reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: widths and named register indices.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // True when an address selects the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: $0 forcing, write-through bypass,
// then the storage mux. Outputs zero while the file is held in reset.
module regfile_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] regs [NREGS],
  output logic [DATA_W-1:0] rd_data
);

  import mips_pkg::*;

  logic addr_is_zero;
  logic bypass_hit;

  assign addr_is_zero = (rd_addr == ADDR_W'(REG_ZERO));
  // A same-cycle write to the addressed register wins over stored contents.
  assign bypass_hit   = we && (wr_addr == rd_addr);

  // Priority: reset, then $0, then bypass, then stored value.
  always_comb begin
    rd_data = '0;
    if (!rst_n || addr_is_zero) begin
      rd_data = '0;
    end else if (bypass_hit) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: two bypassed combinational read ports, one
// synchronous write port, a raw debug read port, and an asynchronous clear.
module mips_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import mips_pkg::*;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  // $0 is never written, so it stays at its reset value of zero.
  assign wr_en = we && (wr_addr != ADDR_W'(REG_ZERO));

  // Storage: asynchronous clear of every entry, otherwise a single-entry write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_rs_port (
    .rst_n   (rst_n),
    .rd_addr (rs_addr),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs_q),
    .rd_data (rs_data)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_rt_port (
    .rst_n   (rst_n),
    .rd_addr (rt_addr),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .regs    (regs_q),
    .rd_data (rt_data)
  );

  // Debug read: raw stored contents, no bypass, $0 and reset read as zero.
  always_comb begin
    dbg_data = '0;
    if (rst_n && (dbg_addr != ADDR_W'(REG_ZERO))) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile: a vector table for the steady-state read/write
// behaviour plus hand-written sequences for reset, sweep and deassertion cases.
module tb_mips_regfile;

  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, wr_data, dbg_data;
  logic        we;

  int n_vec;
  int n_err;

  mips_regfile #(
    .DATA_W (32),
    .ADDR_W (5),
    .NREGS  (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] da, input logic [31:0] ers,
                              input logic [31:0] ert, input logic [31:0] edbg);
    vec_t v;
    v.we = w; v.wr_addr = wa; v.wr_data = wd;
    v.rs_addr = ra; v.rt_addr = rb; v.dbg_addr = da;
    v.exp_rs = ers; v.exp_rt = ert; v.exp_dbg = edbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive all inputs just after a falling edge; outputs are checked 1 time unit
  // later, well before the rising edge that commits any write.
  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
    @(negedge clk);
    we = w; wr_addr = wa; wr_data = wd;
    rs_addr = ra; rt_addr = rb; dbg_addr = da;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    we = 1'b1; wr_addr = REG_T0; wr_data = 32'h1234_5678;
    rs_addr = REG_T0; rt_addr = REG_T0; dbg_addr = REG_T0;

    // Reset state: even a matching bypass must read zero while in reset.
    #1;
    check("reset_rs", rs_data, 32'h0);
    check("reset_rt", rt_data, 32'h0);
    check("reset_dbg", dbg_data, 32'h0);
    @(posedge clk);
    #1;
    check("reset_write_ignored", dbg_data, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;

    // Expected values are pre-edge; each write commits on the following edge.
    vecs[0]  = mk(1, 8,  32'h0000_0011, 8,  8,  8,  32'h11, 32'h11, 32'h0);
    vecs[1]  = mk(0, 8,  32'h0,         8,  8,  8,  32'h11, 32'h11, 32'h11);
    vecs[2]  = mk(1, 0,  32'hFFFF_FFFF, 0,  8,  0,  32'h0,  32'h11, 32'h0);
    vecs[3]  = mk(0, 0,  32'hFFFF_FFFF, 0,  0,  0,  32'h0,  32'h0,  32'h0);
    vecs[4]  = mk(1, 9,  32'h5,         1,  2,  9,  32'h0,  32'h0,  32'h0);
    vecs[5]  = mk(1, 9,  32'h7,         9,  9,  9,  32'h7,  32'h7,  32'h5);
    vecs[6]  = mk(0, 9,  32'h0,         9,  8,  9,  32'h7,  32'h11, 32'h7);
    vecs[7]  = mk(1, 1,  32'h3,         1,  2,  1,  32'h3,  32'h0,  32'h0);
    vecs[8]  = mk(1, 2,  32'h1,         1,  2,  2,  32'h3,  32'h1,  32'h0);
    vecs[9]  = mk(0, 2,  32'h0,         1,  2,  2,  32'h3,  32'h1,  32'h1);
    vecs[10] = mk(1, 31, 32'hCAFE_F00D, 31, 29, 31, 32'hCAFEF00D, 32'h0, 32'h0);
    vecs[11] = mk(0, 8,  32'h99,        8,  31, 31, 32'h11, 32'hCAFEF00D, 32'hCAFEF00D);
    vecs[12] = mk(1, 29, 32'h8000_0000, 29, 31, 29, 32'h80000000, 32'hCAFEF00D, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].wr_addr, vecs[i].wr_data,
            vecs[i].rs_addr, vecs[i].rt_addr, vecs[i].dbg_addr);
      check($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
      check($sformatf("vec%0d_rt", i), rt_data, vecs[i].exp_rt);
      check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      // r1=3, r2=1 feeding an ALU subtract gives 2.
      if (i == 9) check("alu_sub", rs_data - rt_data, 32'h2);
    end

    // $0 stays zero across the edge of a write to it.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    check("zero_during", rs_data, 32'h0);
    @(posedge clk);
    #1;
    check("zero_after_edge", rs_data, 32'h0);
    check("zero_after_dbg", dbg_data, 32'h0);

    // Sweep: r[i] = i * 0x01010101, then read complementary pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i) * 32'h0101_0101, 0, 0, 0);
    end
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      check($sformatf("sweep_rs%0d", i), rs_data, 32'(i) * 32'h0101_0101);
      check($sformatf("sweep_rt%0d", 31 - i), rt_data, 32'(31 - i) * 32'h0101_0101);
      check($sformatf("sweep_dbg%0d", i), dbg_data, 32'(i) * 32'h0101_0101);
    end

    // Mid-cycle reset clears immediately; a write held over an edge in reset is lost.
    drive(1, 5, 32'hDEAD_BEEF, 5, 31, 5);
    @(posedge clk);
    #1;
    check("pre_reset_r5", dbg_data, 32'hDEADBEEF);
    we = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear_rs", rs_data, 32'h0);
    check("async_clear_rt", rt_data, 32'h0);
    check("async_clear_dbg", dbg_data, 32'h0);
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777_7777; rs_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    check("reset_no_bypass", rs_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reset_write_lost", dbg_data, 32'h0);
    rs_addr = REG_RA;
    #1;
    check("reset_cleared_ra", rs_data, 32'h0);

    // First edge after deassertion accepts a write.
    drive(1, 3, 32'h0000_0ABC, 0, 0, 3);
    @(posedge clk);
    #1;
    check("first_write_after_reset", dbg_data, 32'h00000ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
